rasterizer_vertex_fetch_burst: RTL
==================================

Name: rasterizer_vertex_fetch_burst

Overview:
- Parametrised successor to the single-beat vertex fetcher; feeds the rasterizer triangle setup stage.
- On fetch_enable, reads a 32-bit triangle-count header at vertex_buffer_base over the Avalon-MM master.
- Then fetches that many records of RECORD_WORDS words each, one Avalon burst per record.
- Records are buffered in a show-ahead FIFO and presented with a valid/stall handshake; done_out flags completion of the whole buffer.

Parameters:
- ADDR_W, 26, byte address width of master_address and vertex_buffer_base.
- DATA_W, 32, Avalon data width; fixed at 32 for this generation.
- RECORD_WORDS, 15, words per triangle record; legal range 1..64.
- FIFO_DEPTH_LOG2, 4, record FIFO depth is 2**FIFO_DEPTH_LOG2 entries.
- BURST_W, $clog2(RECORD_WORDS+1), width of master_burstcount.

Ports:
- clock  in  1  single clock.
- reset  in  1  synchronous, active-high reset.
- master_address  out  ADDR_W  burst start byte address.
- master_read  out  1  read request.
- master_burstcount  out  BURST_W  beats in the burst.
- master_byteenable  out  4  constant 4'b1111.
- master_write  out  1  constant 0.
- master_writedata  out  DATA_W  constant 0.
- master_readdata  in  DATA_W  returned beat.
- master_readdatavalid  in  1  beat valid.
- master_waitrequest  in  1  command stall.
- fetch_enable  in  1  start pulse; sampled only in IDLE.
- vertex_buffer_base  in  ADDR_W  header address; captured at start.
- stall_in  in  1  downstream not ready.
- output_valid  out  1  FIFO head record valid.
- vertex_out  out  RECORD_WORDS*DATA_W  head record; word 0 in bits [31:0].
- done_out  out  1  all records delivered.
- busy  out  1  not in IDLE/DONE.

Behaviour:
- Reset (synchronous, active-high): every output 0; FIFO cleared; in_flight=0; all counters 0; command FSM to IDLE; beat counter 0.
- Command FSM, IDLE:
  - fetch_enable=1 → capture base; assert read at base, burstcount=1 → HDR_REQ.
  - fetch_enable=0 → stay in IDLE.
- Command FSM, HDR_REQ: hold address, read and burstcount until waitrequest=0 → HDR_WAIT.
- Command FSM, HDR_WAIT:
  - First readdatavalid → tri_num = readdata, next_addr = base+4.
  - tri_num=0 → DONE.
  - tri_num>0 → REC_ARB.
- Command FSM, REC_ARB:
  - Issue condition: issued<tri_num and (fifo_count + in_flight) < 2**FIFO_DEPTH_LOG2.
  - On issue: read=1, address=next_addr, burstcount=RECORD_WORDS → REC_REQ.
- Command FSM, REC_REQ:
  - Hold all command signals stable while waitrequest=1.
  - On acceptance: next_addr += RECORD_WORDS*4 (wraps modulo 2**ADDR_W), issued++, in_flight++, read=0 → REC_ARB.
- Command FSM, DONE:
  - done_out=1 once delivered==tri_num.
  - fetch_enable=1 → clear all counters and restart as from IDLE.
- Receive path:
  - Each readdatavalid outside HDR_WAIT writes assemble[beat]; beat++.
  - On beat==RECORD_WORDS-1: push {assemble, readdata} to FIFO; beat=0; in_flight--.
  - The credit check guarantees the FIFO never overflows; an overflow push is an assertion failure.
  - Simultaneous in_flight++ and in_flight-- in one cycle → net 0.
  - Simultaneous push and pop in one cycle → fifo_count unchanged.
- Output handshake:
  - output_valid = !fifo_empty.
  - Pop when output_valid && !stall_in; delivered++.
  - vertex_out is stable while output_valid=1 and stall_in=1.
  - Latency: last beat to output_valid = 1 cycle when the FIFO was empty.
- Readdatavalid seen in IDLE or DONE is ignored.
- Reset mid-burst aborts; the bench must not return stale beats after reset.

Optional Feature:
- Macro: RASTER_VF_STATS_EN.
- Defined: adds ports stat_stall_cycles (out, 32) and stat_wait_cycles (out, 32), both saturating.
  - stat_stall_cycles counts cycles with output_valid && stall_in.
  - stat_wait_cycles counts cycles with read && waitrequest.
  - Both clear on reset and on each start.
- Undefined: no such ports or logic.

Decomposition:
- Package rasterizer_vf_pkg holds:
  - cmd_state_t enum {IDLE, HDR_REQ, HDR_WAIT, REC_ARB, REC_REQ, DONE}.
  - Function record_stride_bytes(RECORD_WORDS).
- Sub-module rasterizer_vf_fifo: synchronous show-ahead FIFO with parameters DBITS and SIZE; ports wr, rd, din, dout, empty, full, count.

Test Plan:
- Base=0x100, header=0 → one burst of 1 at 0x100; done_out=1 within 3 cycles; output_valid never 1.
- Header=3, RECORD_WORDS=15, no stall:
  - Bursts of 15 at 0x104, 0x140 and 0x17C.
  - Three output_valid pulses with words matching memory.
  - done_out=1 after the third pop.
- Header=40, FIFO depth 16, stall_in held at 1:
  - Exactly 16 bursts issued, then master_read stays 0.
  - Releasing stall resumes issue; all 40 records are delivered.
- waitrequest=1 for 5 cycles on the second burst → address and burstcount held constant; no duplicate burst issued.
- Reset asserted mid-record (beat 7) → all outputs 0 next cycle; a new fetch_enable with header=1 delivers one correct record.
- With RASTER_VF_STATS_EN, stall 4 cycles with a valid head → stat_stall_cycles=4.

Source files
------------

// File: rtl/rasterizer_vf_pkg.sv
// Shared types and helpers for the burst vertex fetcher.
package rasterizer_vf_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR_REQ,
    HDR_WAIT,
    REC_ARB,
    REC_REQ,
    DONE
  } cmd_state_t;

  function automatic int record_stride_bytes(input int words);
    return words * 4;
  endfunction

endpackage

// File: rtl/rasterizer_vf_fifo.sv
// Synchronous show-ahead FIFO: dout always shows the head entry while !empty.
module rasterizer_vf_fifo #(
  parameter int DBITS = 32,
  parameter int SIZE  = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     wr,
  input  logic                     rd,
  input  logic [DBITS-1:0]         din,
  output logic [DBITS-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(SIZE):0]    count
);
  localparam int AW = $clog2(SIZE);

  logic [DBITS-1:0] mem_q [SIZE];
  logic [AW-1:0]    wp_q, rp_q;
  logic [AW:0]      cnt_q;
  logic             do_wr, do_rd;

  assign do_rd = rd && !empty;
  assign do_wr = wr && (!full || do_rd);

  always_ff @(posedge clock) begin
    if (do_wr) mem_q[wp_q] <= din;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_wr) wp_q <= wp_q + 1'b1;
      if (do_rd) rp_q <= rp_q + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign dout  = mem_q[rp_q];
  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == (AW+1)'(SIZE));
  assign count = cnt_q;

endmodule

// File: rtl/rasterizer_vertex_fetch_burst.sv
// Burst vertex fetcher: header read, one Avalon burst per record, show-ahead record FIFO.
// Optional RASTER_VF_STATS_EN adds saturating stall/waitrequest cycle counters.
module rasterizer_vertex_fetch_burst
  import rasterizer_vf_pkg::*;
#(
  parameter int ADDR_W          = 26,
  parameter int DATA_W          = 32,
  parameter int RECORD_WORDS    = 15,
  parameter int FIFO_DEPTH_LOG2 = 4,
  parameter int BURST_W         = $clog2(RECORD_WORDS+1)
) (
  input  logic                           clock,
  input  logic                           reset,
  output logic [ADDR_W-1:0]              master_address,
  output logic                           master_read,
  output logic [BURST_W-1:0]             master_burstcount,
  output logic [3:0]                     master_byteenable,
  output logic                           master_write,
  output logic [DATA_W-1:0]              master_writedata,
  input  logic [DATA_W-1:0]              master_readdata,
  input  logic                           master_readdatavalid,
  input  logic                           master_waitrequest,
  input  logic                           fetch_enable,
  input  logic [ADDR_W-1:0]              vertex_buffer_base,
  input  logic                           stall_in,
  output logic                           output_valid,
  output logic [RECORD_WORDS*DATA_W-1:0] vertex_out,
  output logic                           done_out,
  output logic                           busy
`ifdef RASTER_VF_STATS_EN
  ,
  output logic [31:0]                    stat_stall_cycles,
  output logic [31:0]                    stat_wait_cycles
`endif
);
  localparam int DEPTH = 2**FIFO_DEPTH_LOG2;
  localparam int RBITS = RECORD_WORDS*DATA_W;
  localparam int BW    = (RECORD_WORDS > 1) ? $clog2(RECORD_WORDS) : 1;
  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(record_stride_bytes(RECORD_WORDS));
  localparam logic [FIFO_DEPTH_LOG2+1:0] DEPTH_C = (FIFO_DEPTH_LOG2+2)'(DEPTH);

  cmd_state_t state_q;
  logic [ADDR_W-1:0]    base_q, next_addr_q, addr_q;
  logic                 read_q, done_q;
  logic [BURST_W-1:0]   bc_q;
  logic [31:0]          tri_num_q, issued_q, delivered_q, delivered_d;
  logic [FIFO_DEPTH_LOG2:0]   in_flight_q, in_flight_d, fifo_count;
  logic [FIFO_DEPTH_LOG2+1:0] occ;
  logic [BW-1:0]        beat_q;
  logic [RECORD_WORDS-1:0][DATA_W-1:0] asm_q, push_data;
  logic [RBITS-1:0]     fifo_dout;
  logic rx_en, push, pop, fifo_empty, fifo_full, rec_accept;

  assign rx_en      = master_readdatavalid && (state_q == REC_ARB || state_q == REC_REQ);
  assign push       = rx_en && (beat_q == BW'(RECORD_WORDS-1));
  assign pop        = !fifo_empty && !stall_in;
  assign rec_accept = (state_q == REC_REQ) && !master_waitrequest;
  // Credit counts both buffered records and bursts still returning data.
  assign occ        = {1'b0, fifo_count} + {1'b0, in_flight_q};

  always_comb begin
    in_flight_d = in_flight_q;
    if (rec_accept && !push)      in_flight_d = in_flight_q + 1'b1;
    else if (!rec_accept && push) in_flight_d = in_flight_q - 1'b1;
    delivered_d = delivered_q + {31'b0, pop};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;  base_q <= '0;  next_addr_q <= '0;  addr_q <= '0;
      read_q <= 1'b0;   bc_q <= '0;    done_q <= 1'b0;
      tri_num_q <= '0;  issued_q <= '0; delivered_q <= '0; in_flight_q <= '0;
    end else begin
      in_flight_q <= in_flight_d;
      delivered_q <= delivered_d;
      case (state_q)
        IDLE, DONE: if (fetch_enable) begin
          base_q <= vertex_buffer_base;  addr_q <= vertex_buffer_base;
          read_q <= 1'b1;  bc_q <= BURST_W'(1);  done_q <= 1'b0;
          tri_num_q <= '0; issued_q <= '0; delivered_q <= '0; in_flight_q <= '0;
          state_q <= HDR_REQ;
        end
        HDR_REQ: if (!master_waitrequest) begin
          read_q  <= 1'b0;
          state_q <= HDR_WAIT;
        end
        HDR_WAIT: if (master_readdatavalid) begin
          tri_num_q   <= master_readdata;
          next_addr_q <= base_q + ADDR_W'(4);
          if (master_readdata == '0) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            state_q <= REC_ARB;
          end
        end
        REC_ARB: begin
          if (delivered_d == tri_num_q) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end else if (issued_q < tri_num_q && occ < DEPTH_C) begin
            read_q  <= 1'b1;
            addr_q  <= next_addr_q;
            bc_q    <= BURST_W'(RECORD_WORDS);
            state_q <= REC_REQ;
          end
        end
        REC_REQ: if (!master_waitrequest) begin
          read_q      <= 1'b0;
          next_addr_q <= next_addr_q + STRIDE;
          issued_q    <= issued_q + 32'd1;
          state_q     <= REC_ARB;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      beat_q <= '0;
      asm_q  <= '0;
    end else if (rx_en) begin
      if (push) beat_q <= '0;
      else begin
        asm_q[beat_q] <= master_readdata;
        beat_q        <= beat_q + 1'b1;
      end
    end
  end

  always_comb begin
    push_data = asm_q;
    push_data[RECORD_WORDS-1] = master_readdata;
  end

  always_ff @(posedge clock) begin
    if (!reset) assert (!(push && fifo_full && !pop));
  end

  rasterizer_vf_fifo #(.DBITS(RBITS), .SIZE(DEPTH)) u_fifo (
    .clock(clock), .reset(reset), .wr(push), .rd(pop), .din(push_data),
    .dout(fifo_dout), .empty(fifo_empty), .full(fifo_full), .count(fifo_count)
  );

  assign master_address    = addr_q;
  assign master_read       = read_q;
  assign master_burstcount = bc_q;
  assign master_byteenable = 4'b1111;
  assign master_write      = 1'b0;
  assign master_writedata  = '0;
  assign output_valid      = !fifo_empty;
  // Gate the head so stale RAM contents never leak out after reset.
  assign vertex_out        = fifo_empty ? '0 : fifo_dout;
  assign done_out          = done_q;
  assign busy              = !(state_q == IDLE || state_q == DONE);

`ifdef RASTER_VF_STATS_EN
  logic [31:0] stall_cnt_q, wait_cnt_q;
  always_ff @(posedge clock) begin
    if (reset || ((state_q == IDLE || state_q == DONE) && fetch_enable)) begin
      stall_cnt_q <= '0;
      wait_cnt_q  <= '0;
    end else begin
      if (output_valid && stall_in && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (read_q && master_waitrequest && wait_cnt_q != '1) wait_cnt_q <= wait_cnt_q + 32'd1;
    end
  end
  assign stat_stall_cycles = stall_cnt_q;
  assign stat_wait_cycles  = wait_cnt_q;
`endif

endmodule
